// File: rtl/bms_adc_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : bms_adc_spi_master
//  Description : SPI mode-0 master that round-robin scans channels 0..4 of an
//                external 8-channel 12-bit SAR ADC. It provides the three
//                cell-voltage samples, the pack-current sample and the
//                temperature sample to the BMS top.
//                Optional build macro BMS_ADC_AVG_EN: each channel register
//                holds a rounded two-point running average, not the raw sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module bms_adc_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic        adc_miso,
    output logic        adc_sclk,
    output logic        adc_mosi,
    output logic        adc_cs_n,
    output logic [11:0] cell_1_voltage_adc,
    output logic [11:0] cell_2_voltage_adc,
    output logic [11:0] cell_3_voltage_adc,
    output logic [11:0] pack_current_adc,
    output logic [11:0] temperature_adc,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_GAP_LAST = 8'(CS_GAP - 1);
    localparam logic [2:0] c_LAST_CH  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_div;
    logic [3:0]  r_bit;
    logic [7:0]  r_gap;
    logic        r_sclk;
    logic        r_mosi;
    logic [2:0]  r_ch;
    logic [2:0]  r_sample_ch;
    logic [11:0] r_shift;
    logic [11:0] r_cell_1;
    logic [11:0] r_cell_2;
    logic [11:0] r_cell_3;
    logic [11:0] r_current;
    logic [11:0] r_temp;

    logic        w_div_end;
    logic        w_last_bit;
    logic        w_gap_end;
    logic [15:0] w_cmd;
    logic [3:0]  w_next_bit;
    logic [11:0] w_wr_val;

    // Command word, MSB first: start, single-ended, 3-bit channel code, zeros
    assign w_cmd      = {1'b1, 1'b1, r_ch, 11'b0};
    assign w_div_end  = (r_div == c_DIV_LAST);
    assign w_last_bit = (r_bit == 4'd15);
    assign w_gap_end  = (r_gap == c_GAP_LAST);
    assign w_next_bit = r_bit + 4'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_next       = r_state;
        adc_cs_n     = 1'b1;
        busy         = 1'b1;
        sample_valid = 1'b0;
        frame_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (scan_en) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                adc_cs_n = 1'b0;
                if (w_div_end && r_sclk && w_last_bit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                sample_valid = 1'b1;
                frame_done   = (r_ch == c_LAST_CH);
                w_next       = S_GAP;
            end
            S_GAP: begin
                if (w_gap_end) begin
                    // A frame always runs through channel 4 before scan_en is honoured
                    w_next = ((r_ch != c_LAST_CH) || scan_en) ? S_SHIFT : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // SCLK divider, bit counter, command shifter, MISO capture and gap timer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= 8'd0;
            r_bit       <= 4'd0;
            r_gap       <= 8'd0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_ch        <= 3'd0;
            r_sample_ch <= 3'd0;
            r_shift     <= 12'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_div  <= 8'd0;
                    r_bit  <= 4'd0;
                    r_gap  <= 8'd0;
                    r_sclk <= 1'b0;
                    r_mosi <= 1'b0;
                    if (scan_en) begin
                        r_ch   <= 3'd0;
                        r_mosi <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_div_end) begin
                        r_div <= 8'd0;
                        if (!r_sclk) begin
                            // Rising SCLK: the first four MISO bits are null/settle bits
                            r_sclk <= 1'b1;
                            if (r_bit >= 4'd4) begin
                                r_shift <= {r_shift[10:0], adc_miso};
                            end
                        end else begin
                            // Falling SCLK: MOSI moves at the start of the next low phase
                            r_sclk <= 1'b0;
                            if (w_last_bit) begin
                                r_mosi      <= 1'b0;
                                r_sample_ch <= r_ch;
                            end else begin
                                r_bit  <= w_next_bit;
                                r_mosi <= w_cmd[4'd15 - w_next_bit];
                            end
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_DONE: begin
                    r_gap <= 8'd0;
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_gap <= 8'd0;
                        r_bit <= 4'd0;
                        r_div <= 8'd0;
                        if (r_ch != c_LAST_CH) begin
                            r_ch   <= r_ch + 3'd1;
                            r_mosi <= 1'b1;
                        end else if (scan_en) begin
                            r_ch   <= 3'd0;
                            r_mosi <= 1'b1;
                        end
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                default: begin
                    r_div <= 8'd0;
                end
            endcase
        end
    end

`ifdef BMS_ADC_AVG_EN
    logic [4:0]  r_seen;
    logic [4:0]  w_ch_onehot;
    logic [11:0] w_old;
    logic [12:0] w_sum;

    assign w_ch_onehot = 5'b00001 << r_ch;
    assign w_sum       = {1'b0, w_old} + {1'b0, r_shift} + 13'd1;

    // Select the current contents of the channel being written, and the written value
    always_comb begin
        w_old = 12'd0;
        case (r_ch)
            3'd0:    w_old = r_cell_1;
            3'd1:    w_old = r_cell_2;
            3'd2:    w_old = r_cell_3;
            3'd3:    w_old = r_current;
            3'd4:    w_old = r_temp;
            default: w_old = 12'd0;
        endcase
        w_wr_val = (|(r_seen & w_ch_onehot)) ? w_sum[12:1] : r_shift;
    end

    // Per-channel flag: the first sample after reset is stored without averaging
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen <= 5'd0;
        end else if (r_state == S_DONE) begin
            r_seen <= r_seen | w_ch_onehot;
        end
    end
`else
    assign w_wr_val = r_shift;
`endif

    // Channel result registers change only in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cell_1  <= 12'd0;
            r_cell_2  <= 12'd0;
            r_cell_3  <= 12'd0;
            r_current <= 12'd0;
            r_temp    <= 12'd0;
        end else if (r_state == S_DONE) begin
            case (r_ch)
                3'd0:    r_cell_1  <= w_wr_val;
                3'd1:    r_cell_2  <= w_wr_val;
                3'd2:    r_cell_3  <= w_wr_val;
                3'd3:    r_current <= w_wr_val;
                3'd4:    r_temp    <= w_wr_val;
                default: r_cell_1  <= r_cell_1;
            endcase
        end
    end

    assign adc_sclk           = r_sclk;
    assign adc_mosi           = r_mosi;
    assign sample_ch          = r_sample_ch;
    assign cell_1_voltage_adc = r_cell_1;
    assign cell_2_voltage_adc = r_cell_2;
    assign cell_3_voltage_adc = r_cell_3;
    assign pack_current_adc   = r_current;
    assign temperature_adc    = r_temp;

endmodule
`default_nettype wire

// File: doc/bms_adc_spi_master.md
# bms_adc_spi_master

SPI master that scans an external 8-channel, 12-bit SAR ADC and produces the five raw samples the BMS top consumes: three cell voltages, pack current and temperature. It sits between the board-level ADC pins and the BMS top's `*_adc` inputs. It owns conversion sequencing, chip-select framing, serial shifting and per-channel result registers.

## Interface
- `CLK_DIV`, default 4: clk cycles per SCLK half-period; legal range 2..255.
- `CS_GAP`, default 8: clk cycles `adc_cs_n` stays high between conversions; legal range 1..255.
- `clk` input, 1 bit: system clock; all logic is clocked on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `scan_en` input, 1 bit: enables continuous round-robin scanning while high.
- `adc_miso` input, 1 bit: ADC serial data out.
- `adc_sclk` output, 1 bit: SPI clock, mode 0, idles low.
- `adc_mosi` output, 1 bit: ADC command bit.
- `adc_cs_n` output, 1 bit: ADC chip select, active low.
- `cell_1_voltage_adc`, `cell_2_voltage_adc`, `cell_3_voltage_adc`, `pack_current_adc`, `temperature_adc` outputs, 12 bits each: latest sample per channel.
- `sample_valid` output, 1 bit: one-cycle pulse when any channel register updates.
- `sample_ch` output, 3 bits: index (0..4) of the channel updated with `sample_valid`.
- `frame_done` output, 1 bit: one-cycle pulse coincident with the channel-4 update.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- Channel map, with index equal to the ADC channel code:
  - 0 = cell 1
  - 1 = cell 2
  - 2 = cell 3
  - 3 = pack current
  - 4 = temperature
- Each conversion is 16 SCLK bits, MSB first.
  - MOSI bits 0..4: start=1, single-ended=1, D2, D1, D0 (channel code).
  - MOSI bits 5..15: 0.
  - MISO bits 0..3 are ignored (ADC null/settle bits); bits 4..15 carry result D11..D0.
- State machine:
  - IDLE: `cs_n`=1, `sclk`=0, `mosi`=0. Leaves on `scan_en`=1 and goes to SHIFT with channel 0.
  - SHIFT: `cs_n`=0. Runs 16 bits; each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles. Goes to DONE after the last high phase.
  - DONE: 1 cycle. `cs_n`=1, the channel register is written, `sample_valid`=1 and `sample_ch` = channel. If the channel is 4, `frame_done`=1. Goes to GAP.
  - GAP: CS_GAP cycles with `cs_n`=1. Then:
    - channel < 4: channel+1, go to SHIFT.
    - channel = 4 and `scan_en`=1: channel 0, go to SHIFT.
    - otherwise: go to IDLE.
- Dropping `scan_en` mid-frame does not abort. The current frame completes through channel 4.
- `sample_ch` holds its last value when `sample_valid` is low.
- Received bits shift into a 12-bit register. Channel registers change only in DONE.

## Timing
- MOSI changes on the first cycle of each low phase; it is stable for ≥ CLK_DIV cycles before the rising SCLK edge.
- MISO is sampled on the clk edge where `sclk` transitions 0→1, using a single register (no metastability sync; the ADC is source-synchronous to `sclk`).
- Latency from `cs_n` fall to register update is 32·CLK_DIV + 1 cycles; at defaults this is 129.
- Conversion period is 32·CLK_DIV + 1 + CS_GAP cycles; at defaults this is 137. Frame period is 5× that, 685 cycles.
- Reset (any state, any cycle) applies next edge:
  - state = IDLE
  - `cs_n`=1, `sclk`=0, `mosi`=0
  - all channel registers = 0
  - `sample_valid`=0, `frame_done`=0, `busy`=0, `sample_ch`=0
  - bit counter and divider = 0
  - A partial shift is discarded.
- `rst` and `scan_en` asserted together: reset wins.

## Configuration
- Macro `BMS_ADC_AVG_EN`.
  - Defined: each channel register is written with (old + new + 1) >> 1 using 13-bit intermediate arithmetic. The first sample after reset is written directly, tracked by a per-channel first flag.
  - Undefined: the register is written with the raw new sample.
- Timing and all other outputs are identical in both builds.

## Test plan
- Reset mid-SHIFT (bit 7 of channel 2) → next cycle `cs_n`=1, `sclk`=0, all registers 0, `busy`=0. With `scan_en` held high, scanning restarts at channel 0.
- `scan_en`=1 for one cycle, ADC model returning 0xA5C, 0x123, 0xFFF, 0x000, 0x800 on channels 0..4 → registers match exactly. Five `sample_valid` pulses occur 137 cycles apart, `sample_ch` runs 0..4, `frame_done` coincides with channel 4, then IDLE.
- MOSI capture on channel 3 → first five bits 1,1,0,1,1, then eleven 0s. `cs_n` low for exactly 128 cycles.
- `scan_en` held high for two frames → channel 0 of frame 2 starts CS_GAP=8 cycles after the channel-4 DONE, with no IDLE visit.
- `scan_en` dropped during channel 1 → channels 2..4 still convert, then `busy`=0.
- `BMS_ADC_AVG_EN` build, channel 0 samples 0x100 then 0x201 → register reads 0x100, then 0x181.
